sd_sector_writer: RTL and testbench

Write-side counterpart of the SD metadata/song loader. It accepts a stream of 32-bit words, packs them into 512-byte sectors, and drives the write port of sd_controller: wr, din, ready_for_next_byte, ready and address. Byte order is MSB-first, so a sector written here reads back into identical words through the existing byte-to-word read path. It runs in the clk25 domain beside sd_controller and is used for saving scores and calibration data.

---
 rtl/sd_sector_writer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sd_sector_writer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_writer.sv
`default_nettype none
// ============================================================================
//  Module   : sd_sector_writer
//  Purpose  : Packs a stream of 32-bit words into 512-byte sectors and drives
//             the write port of sd_controller (wr / din / ready_for_next_byte
//             / ready / address). Bytes go out MSB-first, so a sector written
//             here reads back as identical words through the byte-to-word read
//             path. Runs in the clk25 domain next to sd_controller.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk25                  in   1  25 MHz clock shared with sd_controller
//    reset                  in   1  synchronous active-high reset
//    start                  in   1  pulse: open a session at BASE_ADR
//    word_valid / word_in   in   1/32 word stream, byte0 = word_in[31:24]
//    word_ready             out  1  word accepted this cycle when valid
//    flush                  in   1  pulse: write the partial sector, then end
//    sd_ready               in   1  sd_controller.ready
//    sd_wr                  out  1  sd_controller.wr
//    sd_din                 out  8  sd_controller.din (registered)
//    sd_ready_for_next_byte in   1  sd_controller.ready_for_next_byte
//    sd_address             out  32 sd_controller.address
//    busy / done            out  1  session active / session finished
//    sectors_written        out  16 sectors completed in this session
//  Build option
//    DOUBLE_BUFFER_EN : ping-pong pair of sector buffers so filling continues
//                       while the previous sector is being written.
// ============================================================================
module sd_sector_writer #(
  parameter logic [31:0] BASE_ADR    = 32'h0002_0000,
  parameter int          MAX_SECTORS = 64,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_in,
  output logic        word_ready,
  input  logic        flush,
  input  logic        sd_ready,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  input  logic        sd_ready_for_next_byte,
  output logic [31:0] sd_address,
  output logic        busy,
  output logic        done,
  output logic [15:0] sectors_written
);

  localparam logic [15:0] MAX_SECT         = 16'(MAX_SECTORS);
  localparam logic [7:0]  WORDS_PER_SECTOR = 8'd128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_PAD    = 3'd2,
    S_ARM    = 3'd3,
    S_SEND   = 3'd4,
    S_WAIT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [9:0]  bidx, bidx_next;
  logic        rfnb_q;
  logic        byte_edge;
  logic        lastflag;
  logic        hs;
  logic        wait_done;
  logic        flush_req;
  logic [7:0]  fill_cnt;       // words in the buffer being filled
  logic [7:0]  send_cnt;       // words in the buffer being sent
  logic [7:0]  fill_cnt_next;
  logic [31:0] rd_word;
  logic [7:0]  send_byte;

  // One byte per 0->1 transition; a level held high counts once.
  assign byte_edge     = sd_ready_for_next_byte && !rfnb_q;
  assign wait_done     = (state == S_WAIT) && sd_ready;
  assign hs            = word_valid && word_ready;
  assign fill_cnt_next = fill_cnt + {7'd0, hs};
  // Gated by reset so the write strobe drops in the same cycle reset rises.
  assign sd_wr         = (state == S_ARM) && sd_ready && !reset;

`ifdef DOUBLE_BUFFER_EN
  logic [31:0] mem [0:255];
  logic [7:0]  wcnt0, wcnt1;
  logic        fsel, ssel;
  logic        flush_pend;
  logic        launch;
  logic        more_allowed;

  assign fill_cnt  = fsel ? wcnt1 : wcnt0;
  assign send_cnt  = ssel ? wcnt1 : wcnt0;
  // A flush seen while a sector is in flight is held until FILL resumes.
  assign flush_req = flush || flush_pend;
  assign launch    = ((state == S_FILL) && (state_next == S_ARM)) || (state == S_PAD);
  // Keep filling behind an in-flight sector only if it is not the last one.
  assign more_allowed = (sectors_written + 16'd1) < MAX_SECT;

  always_comb begin
    word_ready = 1'b0;
    if (!flush_pend && (fill_cnt < WORDS_PER_SECTOR)) begin
      if (state == S_FILL)
        word_ready = 1'b1;
      else if (state inside {S_ARM, S_SEND, S_WAIT})
        word_ready = more_allowed;
    end
  end

  always_ff @(posedge clk25) begin
    if (hs)
      mem[{fsel, fill_cnt[6:0]}] <= word_in;
  end

  assign rd_word = mem[{ssel, bidx_next[8:2]}];

  always_ff @(posedge clk25) begin
    if (reset) begin
      wcnt0      <= 8'd0;
      wcnt1      <= 8'd0;
      fsel       <= 1'b0;
      ssel       <= 1'b0;
      flush_pend <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        wcnt0      <= 8'd0;
        wcnt1      <= 8'd0;
        fsel       <= 1'b0;
        ssel       <= 1'b0;
        flush_pend <= 1'b0;
      end
    end else begin
      if (state == S_FINISH)
        flush_pend <= 1'b0;
      else if (flush)
        flush_pend <= 1'b1;
      // Hand the filled buffer to the write side, keep filling the other.
      if (launch) begin
        ssel <= fsel;
        fsel <= ~fsel;
      end
      if (wait_done && !ssel)
        wcnt0 <= 8'd0;
      else if (hs && !fsel)
        wcnt0 <= wcnt0 + 8'd1;
      if (wait_done && ssel)
        wcnt1 <= 8'd0;
      else if (hs && fsel)
        wcnt1 <= wcnt1 + 8'd1;
    end
  end
`else
  logic [31:0] mem [0:127];
  logic [7:0]  wcnt;

  assign fill_cnt   = wcnt;
  assign send_cnt   = wcnt;
  assign flush_req  = flush;
  assign word_ready = (state == S_FILL) && (wcnt < WORDS_PER_SECTOR);

  always_ff @(posedge clk25) begin
    if (hs)
      mem[wcnt[6:0]] <= word_in;
  end

  assign rd_word = mem[bidx_next[8:2]];

  always_ff @(posedge clk25) begin
    if (reset)
      wcnt <= 8'd0;
    else if (((state == S_IDLE) && start) || wait_done)
      wcnt <= 8'd0;
    else if (hs)
      wcnt <= wcnt + 8'd1;
  end
`endif

  // Byte pointer as it will be after this edge; sd_din is loaded from it so
  // the next byte is presented the cycle after the edge.
  always_comb begin
    bidx_next = bidx;
    if (state == S_ARM)
      bidx_next = 10'd0;
    else if ((state == S_SEND) && byte_edge)
      bidx_next = bidx + 10'd1;
  end

  // Slots past the stored words read as PAD_BYTE, so padding needs no writes.
  always_comb begin
    send_byte = PAD_BYTE;
    if ({1'b0, bidx_next[8:2]} < send_cnt) begin
      case (bidx_next[1:0])
        2'd0:    send_byte = rd_word[31:24];
        2'd1:    send_byte = rd_word[23:16];
        2'd2:    send_byte = rd_word[15:8];
        default: send_byte = rd_word[7:0];
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:
        if (start) state_next = S_FILL;
      S_FILL:
        // A word arriving with flush is counted before deciding pad vs finish.
        if (flush_req)
          state_next = (fill_cnt_next != 8'd0) ? S_PAD : S_FINISH;
        else if (fill_cnt == WORDS_PER_SECTOR)
          state_next = S_ARM;
      S_PAD:
        state_next = S_ARM;
      S_ARM:
        if (sd_ready) state_next = S_SEND;
      S_SEND:
        if (byte_edge && (bidx == 10'd511)) state_next = S_WAIT;
      S_WAIT:
        if (sd_ready)
          state_next = (lastflag || ((sectors_written + 16'd1) == MAX_SECT))
                       ? S_FINISH : S_FILL;
      S_FINISH:
        state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      state           <= S_IDLE;
      bidx            <= 10'd0;
      rfnb_q          <= 1'b0;
      sd_din          <= 8'h00;
      sd_address      <= BASE_ADR;
      busy            <= 1'b0;
      done            <= 1'b0;
      sectors_written <= 16'd0;
      lastflag        <= 1'b0;
    end else begin
      state  <= state_next;
      rfnb_q <= sd_ready_for_next_byte;
      if ((state == S_ARM) || (state == S_SEND)) begin
        bidx   <= bidx_next;
        sd_din <= send_byte;
      end
      case (state)
        S_IDLE:
          if (start) begin
            sd_address      <= BASE_ADR;
            sectors_written <= 16'd0;
            busy            <= 1'b1;
            done            <= 1'b0;
            lastflag        <= 1'b0;
          end
        S_PAD:
          lastflag <= 1'b1;
        S_WAIT:
          if (sd_ready) begin
            sectors_written <= sectors_written + 16'd1;
            sd_address      <= sd_address + 32'd512;
          end
        S_FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_sector_writer
//  Purpose  : Self-checking bench for sd_sector_writer. The driver feeds words
//             and pushes the expected sector bytes/addresses into queues; an
//             independent SD-side process plays sd_controller and compares
//             every byte and write address it receives.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_sector_writer;

  localparam int          MAXS = 2;
  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam logic [7:0]  PAD  = 8'h00;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        start;
  logic        word_valid;
  logic [31:0] word_in;
  logic        word_ready;
  logic        flush;
  logic        sd_ready;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic        rfnb;
  logic [31:0] sd_address;
  logic        busy;
  logic        done;
  logic [15:0] sectors_written;

  always #10 clk25 = ~clk25;

  sd_sector_writer #(
    .BASE_ADR    (BASE),
    .MAX_SECTORS (MAXS),
    .PAD_BYTE    (PAD)
  ) dut (
    .clk25                  (clk25),
    .reset                  (reset),
    .start                  (start),
    .word_valid             (word_valid),
    .word_in                (word_in),
    .word_ready             (word_ready),
    .flush                  (flush),
    .sd_ready               (sd_ready),
    .sd_wr                  (sd_wr),
    .sd_din                 (sd_din),
    .sd_ready_for_next_byte (rfnb),
    .sd_address             (sd_address),
    .busy                   (busy),
    .done                   (done),
    .sectors_written        (sectors_written)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard queues and reference model state
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mdl_words[$];
  logic [31:0] mdl_addr;

  int wr_pulses   = 0;
  int bytes_seen  = 0;
  int hold_cycles = 0;   // 0 = random high time per byte

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_start();
    mdl_words.delete();
    mdl_addr = BASE;
  endfunction

  function automatic void emit_sector();
    logic [31:0] w;
    exp_addr.push_back(mdl_addr);
    for (int i = 0; i < 512; i++) begin
      if ((i / 4) < mdl_words.size()) begin
        w = mdl_words[i / 4];
        exp_bytes.push_back(w[8 * (3 - (i % 4)) +: 8]);
      end else begin
        exp_bytes.push_back(PAD);
      end
    end
    mdl_addr = mdl_addr + 32'd512;
    mdl_words.delete();
  endfunction

  function automatic void model_word(input logic [31:0] w);
    mdl_words.push_back(w);
    if (mdl_words.size() == 128) emit_sector();
  endfunction

  function automatic void model_flush();
    if (mdl_words.size() > 0) emit_sector();
  endfunction

  // ---------------- SD-side monitor / responder ----------------
  task automatic serve_sector();
    int lo;
    int hi;
    bytes_seen = 0;
    for (int k = 0; k < 512; k++) begin
      lo = int'($urandom_range(1, 3));
      hi = (hold_cycles > 0) ? hold_cycles : int'($urandom_range(1, 3));
      for (int j = 0; j < lo; j++) begin
        @(negedge clk25); #1;
        if (reset) begin rfnb = 1'b0; return; end
      end
      if (exp_bytes.size() == 0) check("unexpected_byte", 32'd1, 32'd0);
      else check("sd_din", {24'd0, sd_din}, {24'd0, exp_bytes.pop_front()});
      rfnb = 1'b1;
      bytes_seen++;
      for (int j = 0; j < hi; j++) begin
        @(negedge clk25); #1;
        if (reset) begin rfnb = 1'b0; return; end
      end
      rfnb = 1'b0;
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk25); #1;
    end
  endtask

  initial begin
    sd_ready = 1'b1;
    rfnb     = 1'b0;
    forever begin
      @(negedge clk25); #1;
      if (!reset && sd_wr) begin
        wr_pulses++;
        if (exp_addr.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
        else check("sd_address", sd_address, exp_addr.pop_front());
        @(negedge clk25); #1;
        check("sd_wr_one_cycle", {31'd0, sd_wr}, 32'd0);
        sd_ready = 1'b0;
        serve_sector();
        sd_ready = 1'b1;
        rfnb     = 1'b0;
      end
    end
  end

  // ---------------- driver helpers (act on negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk25);
    start = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk25);
    flush = 1'b0;
  endtask

  task automatic send_words(input int n, input int max_cyc, input bit pat, output int acc);
    acc = 0;
    for (int c = 0; (c < max_cyc) && (acc < n); c++) begin
      word_valid = ($urandom_range(0, 3) != 0);
      word_in    = pat ? (32'h0001_0203 + 32'(acc) * 32'h0404_0404) : $urandom();
      if (word_valid && word_ready) begin
        model_word(word_in);
        acc++;
      end
      @(negedge clk25);
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_sectors(input int n, input int max_cyc);
    int c = 0;
    while ((int'(sectors_written) < n) && (c < max_cyc)) begin
      @(negedge clk25);
      c++;
    end
    check("sectors_written_reached", {16'd0, sectors_written}, 32'(n));
  endtask

  task automatic wait_word_ready(input int max_cyc);
    int c = 0;
    while (!word_ready && (c < max_cyc)) begin
      @(negedge clk25);
      c++;
    end
    check("word_ready_refill", {31'd0, word_ready}, 32'd1);
  endtask

  task automatic wait_done(input int max_cyc, input string nm);
    int c = 0;
    while (!done && (c < max_cyc)) begin
      @(negedge clk25);
      c++;
    end
    check(nm, {31'd0, done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int w0;
    int c;
    reset = 1'b1; start = 1'b0; flush = 1'b0; word_valid = 1'b0; word_in = 32'd0;
    repeat (3) @(negedge clk25);
    check("rst_word_ready", {31'd0, word_ready}, 32'd0);
    check("rst_sd_wr",      {31'd0, sd_wr},      32'd0);
    check("rst_sd_din",     {24'd0, sd_din},     32'd0);
    check("rst_sd_address", sd_address,          BASE);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_sectors",    {16'd0, sectors_written}, 32'd0);
    reset = 1'b0;
    @(negedge clk25);

    // 1: one full sector of ramp words, then refill at the next address
    model_start();
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_words(128, 2000, 1'b1, acc);
    check("t1_words", 32'(acc), 32'd128);
    wait_sectors(1, 8000);
    wait_word_ready(20);
    check("t1_next_addr", sd_address, BASE + 32'd512);
    w0 = wr_pulses;
    pulse_flush();
    model_flush();
    wait_done(20, "t1_done");
    check("t1_no_extra_wr", 32'(wr_pulses), 32'(w0));
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: five words then flush -> padded sector
    model_start();
    pulse_start();
    send_words(5, 200, 1'b0, acc);
    check("t2_words", 32'(acc), 32'd5);
    pulse_flush();
    model_flush();
    wait_done(8000, "t2_done");
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_sectors", {16'd0, sectors_written}, 32'd1);
    check("t2_bytes_left", 32'(exp_bytes.size()), 32'd0);

    // 3: flush with no words -> no write, done quickly
    model_start();
    pulse_start();
    w0 = wr_pulses;
    pulse_flush();
    c = 0;
    while (!done && (c < 3)) begin
      @(negedge clk25);
      c++;
    end
    check("t3_done_fast", {31'd0, done}, 32'd1);
    check("t3_no_wr", 32'(wr_pulses), 32'(w0));

    // 4: ready_for_next_byte held high 4 cycles per byte
    hold_cycles = 4;
    model_start();
    pulse_start();
    send_words(128, 2000, 1'b0, acc);
    wait_sectors(1, 12000);
    wait_word_ready(20);
    pulse_flush();
    model_flush();
    wait_done(20, "t4_done");
    check("t4_bytes_left", 32'(exp_bytes.size()), 32'd0);
    hold_cycles = 0;

    // 5: reset in the middle of a sector, then a clean session
    bytes_seen = 0;
    model_start();
    pulse_start();
    send_words(128, 2000, 1'b0, acc);
    c = 0;
    while ((bytes_seen < 200) && (c < 6000)) begin
      @(negedge clk25);
      c++;
    end
    check("t5_reached_byte200", {31'd0, (bytes_seen >= 200)}, 32'd1);
    reset = 1'b1;
    @(negedge clk25);
    check("t5_sd_wr",   {31'd0, sd_wr}, 32'd0);
    check("t5_busy",    {31'd0, busy},  32'd0);
    check("t5_done",    {31'd0, done},  32'd0);
    check("t5_address", sd_address,     BASE);
    check("t5_sectors", {16'd0, sectors_written}, 32'd0);
    reset = 1'b0;
    @(negedge clk25);
    @(negedge clk25);
    exp_bytes.delete();
    exp_addr.delete();
    model_start();
    pulse_start();
    send_words(128, 2000, 1'b0, acc);
    wait_sectors(1, 8000);
    wait_word_ready(20);
    pulse_flush();
    model_flush();
    wait_done(20, "t5_done_after");
    check("t5_bytes_left", 32'(exp_bytes.size()), 32'd0);

    // 6: session limit of MAXS sectors stops word intake
    model_start();
    pulse_start();
    send_words(300, 12000, 1'b0, acc);
    check("t6_words_accepted", 32'(acc), 32'(MAXS * 128));
    wait_done(100, "t6_done");
    check("t6_sectors", {16'd0, sectors_written}, 32'(MAXS));
    check("t6_word_ready", {31'd0, word_ready}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_wr_count_left", 32'(exp_addr.size()), 32'd0);
    check("t6_bytes_left", 32'(exp_bytes.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #4_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
